// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for the shared-register arbiter family.
// Holds the arbiter state encoding, the owner-index width helper and
// the default write-counter width.
package shared_reg_pkg;

  // ARB: plain round-robin; LOCKED: one requester holds exclusive access
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CNT_W_DEFAULT = 16;

  // Width of an index able to address n requesters (never narrower than 1)
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker over a request vector.
// Searches from ptr upwards with wraparound; the first set request wins.
// Zero latency; found=0 and onehot=0 when no request is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk ptr, ptr+1, ... modulo N and latch the first active requester
  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter in front of one shared WIDTH-bit register.
// Grant is combinational; q/q_owner/wr_count update one cycle after the grant edge.
// stall suppresses all grants; optional exclusive lock via SHARED_REG_LOCK_EN.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WIDTH-1:0]      wdata,
  input  logic                        stall,
`ifdef SHARED_REG_LOCK_EN
  input  logic [N_REQ-1:0]            lock,
`endif
  output logic [N_REQ-1:0]            gnt,
  output logic [WIDTH-1:0]            q,
  output logic [owner_w(N_REQ)-1:0]   q_owner,
  output logic                        q_valid,
  output logic [CNT_W-1:0]            wr_count
);

  localparam int IW = owner_w(N_REQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            wr;
`ifdef SHARED_REG_LOCK_EN
  logic [IW-1:0]   lk;
`endif

  // Index following k, wrapping N_REQ-1 back to 0
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : k + IW'(1);
  endfunction

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // FSM next-state: enter LOCKED on a locking write, leave when the owner releases
  always_comb begin
    state_nxt = state;
`ifdef SHARED_REG_LOCK_EN
    case (state)
      ARB:     if (wr && lock[win_idx]) state_nxt = LOCKED;
      LOCKED:  if (!lock[lk])           state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
`else
    state_nxt = ARB;
`endif
  end

  // FSM outputs: one-hot grant and the index of the granted requester
  always_comb begin
    gnt     = '0;
    win_idx = pick_idx;
    if (!reset && !stall) begin
      if (state == ARB) begin
        if (pick_found) gnt = pick_oh;
      end
`ifdef SHARED_REG_LOCK_EN
      else if (req[lk]) begin
        gnt[lk] = 1'b1;
        win_idx = lk;
      end
`endif
    end
  end

  // A grant is only ever issued to an active requester, so any grant is a write
  assign wr = |gnt;

  // Shared register, owner, write pulse, counter and priority pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q        <= '0;
      q_owner  <= '0;
      q_valid  <= 1'b0;
      wr_count <= '0;
      ptr      <= '0;
`ifdef SHARED_REG_LOCK_EN
      lk       <= '0;
`endif
    end else begin
      q_valid <= wr;
      if (wr) begin
        q        <= wdata[int'(win_idx)*WIDTH +: WIDTH];
        q_owner  <= win_idx;
        wr_count <= wr_count + CNT_W'(1);
      end
`ifdef SHARED_REG_LOCK_EN
      if (state == ARB) begin
        if (wr) ptr <= next_idx(win_idx);
        if (wr && lock[win_idx]) lk <= win_idx;
      end else if (!lock[lk]) begin
        // Release resumes round-robin just past the lock owner
        ptr <= next_idx(lk);
      end
`else
      if (wr) ptr <= next_idx(win_idx);
`endif
    end
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin write arbiter sharing one WIDTH-bit storage register, a bank of D flip-flops, between N_REQ requesters. Each cycle it grants at most one requester, captures that requester's data into the shared register, and reports the owner and a write count. It sits between the register's clients and the flop bank, and is the only writer of that bank.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width of the shared register
CNT_W, 16, width of the write counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester write request (level)
wdata  in  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
stall  in  1  when high, no grant is issued this cycle
gnt  out  N_REQ  one-hot grant, combinational; a write occurs on the edge where req[i]&gnt[i]
q  out  WIDTH  shared register contents (registered)
q_owner  out  $clog2(N_REQ)  index of the requester that last wrote q (registered)
q_valid  out  1  one-cycle pulse, cycle after each write
wr_count  out  CNT_W  total accepted writes (registered)

Behaviour:
- Reset (async, active-high): q=0, q_owner=0, q_valid=0, wr_count=0, ptr=0, state=ARB. gnt=0 while reset is high.
- ptr: registered index of the highest-priority requester. Search order is ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1. The first requester with req set wins.
- gnt: one-hot of the winner. All zeros if req==0 or stall==1. At most one bit is ever set.
- On a clock edge with gnt[k]=1:
  - q <= wdata[k]
  - q_owner <= k
  - q_valid <= 1
  - wr_count <= wr_count+1, wrapping from 2^CNT_W-1 to 0
  - ptr <= (k+1) mod N_REQ
- Otherwise: q, q_owner, and ptr hold, and q_valid <= 0.
- Write latency: new data is visible on q one cycle after the grant edge.
- Requester protocol: a requester may keep req high. It is re-granted only after every other active requester has been served. Dropping req without a grant is legal and causes no write.
- stall high: gnt=0 and ptr holds. Pending requests keep their priority order.
- Boundary cases:
  - Single requester asserting every cycle is granted every cycle (throughput 1/cycle).
  - ptr wraps from N_REQ-1 to 0.
  - req changing in the same cycle as stall falling is arbitrated combinationally in that cycle.
- Reset mid-operation clears everything immediately. No partial write is possible, because the write is a single edge.
- States: ARB only without the optional feature; ARB and LOCKED with it (see below).

Optional Feature:
Macro SHARED_REG_LOCK_EN.
- With it, an extra input port is added: lock in N_REQ, a per-requester lock request.
- ARB -> LOCKED: on a write by k with lock[k]=1. The lock owner lk is set to k.
- In LOCKED:
  - gnt = onehot(lk) when req[lk]&!stall, otherwise 0. Other requesters are blocked.
  - ptr does not advance.
- LOCKED -> ARB: on any edge where lock[lk]=0. ptr is then set to (lk+1) mod N_REQ.
- Reset forces ARB.
- Without the macro, the lock port does not exist and the block behaves purely round-robin.

Decomposition:
- Package shared_reg_pkg holds:
  - the state enum (ARB, LOCKED)
  - the function that maps owner index width to $clog2
  - a localparam default for CNT_W
- One natural sub-module: rr_pick. It is combinational; inputs are req and ptr, outputs are the one-hot winner and its index. It is reused by other arbiters.
- The storage register, counter, and FSM stay in the top module.

Test Plan:
- Reset check: assert reset mid-stream with q=0xA5 -> q=0, wr_count=0, gnt=0, q_valid=0 immediately (asynchronous).
- Priority after reset: req=4'b1111 held, N_REQ=4 -> gnt sequence 0001, 0010, 0100, 1000, 0001; q follows wdata of each requester one cycle later; wr_count=5 after 5 grants.
- Sparse requests: req=4'b1010 with ptr=0 -> gnt=0010, then 1000, then 0010; q_owner sequence 1, 3, 1.
- Stall: req=4'b0100 with stall=1 for 3 cycles -> gnt=0, q holds, q_valid=0; stall drops -> gnt=0100 the same cycle, q updated next cycle.
- Counter wrap: with CNT_W=4, perform 17 writes -> wr_count reads 1.
- Lock (SHARED_REG_LOCK_EN): requester 2 writes with lock=1 while req=4'b1111 -> the next 3 grants all go to 2; lock drops -> the next grant goes to 3.
